// File: rtl/oht_multi.sv
// Multi-channel online health test: per-channel repetition-count and adaptive-proportion
// tests with bidirectional p/n trim steering, validity and sticky failure reporting.
module oht_multi #(
    parameter int N_CH     = 4,
    parameter int CAL_W    = 6,
    parameter int WIN      = 1024,
    parameter int RCT_CUT  = 8,
    parameter int APT_LO   = 460,
    parameter int APT_HI   = 562,
    parameter int GOOD_REQ = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_CH-1:0]           bit_in,
    input  logic                      bit_vld,
    input  logic                      debug_mode,
    input  logic [$clog2(N_CH)-1:0]   dbg_sel,
    input  logic [2*CAL_W-1:0]        dbg_cal,
    output logic [N_CH*CAL_W-1:0]     cal_n,
    output logic [N_CH*CAL_W-1:0]     cal_p,
    output logic [N_CH-1:0]           valid,
    output logic [N_CH-1:0]           perm_fail,
    output logic                      any_valid
);
    localparam int ONES_W = $clog2(WIN) + 1;
    localparam int SAMP_W = $clog2(WIN);
    localparam int RUN_W  = $clog2(RCT_CUT + 1);
    localparam int GOOD_W = $clog2(GOOD_REQ + 1);
    localparam int SEL_W  = $clog2(N_CH);

    localparam logic [CAL_W:0]      CAL_MAX   = {1'b0, {CAL_W{1'b1}}};
    localparam logic [ONES_W-1:0]   TH_P3     = ONES_W'(WIN / 8);
    localparam logic [ONES_W-1:0]   TH_P2     = ONES_W'(WIN / 4);
    localparam logic [ONES_W-1:0]   TH_P1     = ONES_W'(APT_LO);
    localparam logic [ONES_W-1:0]   TH_HI     = ONES_W'(APT_HI);
    localparam logic [ONES_W-1:0]   TH_N1     = ONES_W'(3 * WIN / 4);
    localparam logic [ONES_W-1:0]   TH_N2     = ONES_W'(7 * WIN / 8);
    localparam logic [SAMP_W-1:0]   SAMP_LAST = SAMP_W'(WIN - 1);
    localparam logic [RUN_W-1:0]    RUN_TRIP  = RUN_W'(RCT_CUT);
    localparam logic [GOOD_W-1:0]   GOOD_LAST = GOOD_W'(GOOD_REQ - 1);

    typedef enum logic [1:0] {CAL, OK, FAIL} state_t;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        state_t             state, state_nx;
        logic [RUN_W-1:0]   run, run_nx, run_inc;
        logic               last, last_nx;
        logic [ONES_W-1:0]  ones, ones_nx, ones_inc;
        logic [SAMP_W-1:0]  samp, samp_nx;
        logic [GOOD_W-1:0]  good, good_nx;
        logic [CAL_W-1:0]   trim_n, trim_p, trim_n_nx, trim_p_nx;
        logic               adj_req, adj_to_n;
        logic [1:0]         adj_step;
        logic [CAL_W:0]     tgt, opp, step_ext;

        always_ff @(posedge clk) begin
            if (rst) begin
                state  <= CAL;
                run    <= '0;
                last   <= 1'b0;
                ones   <= '0;
                samp   <= '0;
                good   <= '0;
                trim_n <= '0;
                trim_p <= '0;
            end else begin
                state  <= state_nx;
                run    <= run_nx;
                last   <= last_nx;
                ones   <= ones_nx;
                samp   <= samp_nx;
                good   <= good_nx;
                trim_n <= trim_n_nx;
                trim_p <= trim_p_nx;
            end
        end

        // An RCT trip pre-empts a coinciding window end, so only one adjust is ever requested.
        always_comb begin
            state_nx  = state;
            run_nx    = run;
            last_nx   = last;
            ones_nx   = ones;
            samp_nx   = samp;
            good_nx   = good;
            trim_n_nx = trim_n;
            trim_p_nx = trim_p;
            run_inc   = '0;
            ones_inc  = '0;
            adj_req   = 1'b0;
            adj_to_n  = 1'b0;
            adj_step  = '0;
            tgt       = '0;
            opp       = '0;
            step_ext  = '0;
            if (bit_vld && state != FAIL) begin
                run_inc  = (run != '0 && bit_in[i] == last) ? run + RUN_W'(1) : RUN_W'(1);
                ones_inc = ones + ONES_W'(bit_in[i]);
                last_nx  = bit_in[i];
                if (run_inc >= RUN_TRIP) begin
                    run_nx   = '0;
                    ones_nx  = '0;
                    samp_nx  = '0;
                    good_nx  = '0;
                    state_nx = CAL;
                    adj_req  = 1'b1;
                    adj_to_n = bit_in[i];
                    adj_step = 2'd3;
                end else begin
                    run_nx = run_inc;
                    if (samp == SAMP_LAST) begin
                        ones_nx = '0;
                        samp_nx = '0;
                        if (ones_inc < TH_P3) begin
                            adj_req = 1'b1; adj_to_n = 1'b0; adj_step = 2'd3;
                        end else if (ones_inc < TH_P2) begin
                            adj_req = 1'b1; adj_to_n = 1'b0; adj_step = 2'd2;
                        end else if (ones_inc < TH_P1) begin
                            adj_req = 1'b1; adj_to_n = 1'b0; adj_step = 2'd1;
                        end else if (ones_inc <= TH_HI) begin
                            adj_req = 1'b0;
                        end else if (ones_inc < TH_N1) begin
                            adj_req = 1'b1; adj_to_n = 1'b1; adj_step = 2'd1;
                        end else if (ones_inc < TH_N2) begin
                            adj_req = 1'b1; adj_to_n = 1'b1; adj_step = 2'd2;
                        end else begin
                            adj_req = 1'b1; adj_to_n = 1'b1; adj_step = 2'd3;
                        end
                        if (adj_req) begin
                            good_nx  = '0;
                            state_nx = CAL;
                        end else if (state == CAL) begin
                            if (good == GOOD_LAST) begin
                                good_nx  = '0;
                                state_nx = OK;
                            end else begin
                                good_nx = good + GOOD_W'(1);
                            end
                        end
                    end else begin
                        ones_nx = ones_inc;
                        samp_nx = samp + SAMP_W'(1);
                    end
                end
                // A saturated target is compensated by backing off the opposite trim instead.
                if (adj_req) begin
                    step_ext = (CAL_W + 1)'(adj_step);
                    tgt = adj_to_n ? {1'b0, trim_n} : {1'b0, trim_p};
                    opp = adj_to_n ? {1'b0, trim_p} : {1'b0, trim_n};
                    if (tgt != CAL_MAX) begin
                        tgt = (tgt + step_ext > CAL_MAX) ? CAL_MAX : tgt + step_ext;
                        if (adj_to_n) trim_n_nx = tgt[CAL_W-1:0];
                        else          trim_p_nx = tgt[CAL_W-1:0];
                    end else if (opp != '0) begin
                        opp = (opp > step_ext) ? opp - step_ext : '0;
                        if (adj_to_n) trim_p_nx = opp[CAL_W-1:0];
                        else          trim_n_nx = opp[CAL_W-1:0];
                    end else begin
                        state_nx = FAIL;
                    end
                end
            end
            if (debug_mode && dbg_sel == SEL_W'(i)) begin
                trim_n_nx = dbg_cal[2*CAL_W-1:CAL_W];
                trim_p_nx = dbg_cal[CAL_W-1:0];
            end
        end

        assign cal_n[i*CAL_W +: CAL_W] = trim_n;
        assign cal_p[i*CAL_W +: CAL_W] = trim_p;
        assign valid[i]                = (state == OK);
        assign perm_fail[i]            = (state == FAIL);
    end

    assign any_valid = |valid;

endmodule

// File: tb/tb_oht_multi.sv
// Randomised bench for oht_multi: every cycle the outputs are compared against a
// sample-level behavioural model of the health tests, plus directed milestone checks.
module tb_oht_multi;
    localparam int N_CH     = 4;
    localparam int CAL_W    = 6;
    localparam int WIN      = 1024;
    localparam int RCT_CUT  = 8;
    localparam int APT_LO   = 460;
    localparam int APT_HI   = 562;
    localparam int GOOD_REQ = 2;
    localparam int TMAX     = (1 << CAL_W) - 1;
    localparam int ST_CAL = 0, ST_OK = 1, ST_FAIL = 2;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [N_CH-1:0]         bit_in;
    logic                    bit_vld;
    logic                    debug_mode;
    logic [1:0]              dbg_sel;
    logic [2*CAL_W-1:0]      dbg_cal;
    logic [N_CH*CAL_W-1:0]   cal_n, cal_p;
    logic [N_CH-1:0]         valid, perm_fail;
    logic                    any_valid;

    int n_checks = 0;
    int n_fail   = 0;

    int m_n[N_CH], m_p[N_CH], m_st[N_CH], m_run[N_CH], m_last[N_CH];
    int m_ones[N_CH], m_samp[N_CH], m_good[N_CH];
    int g_pct[N_CH], g_hold[N_CH], g_run[N_CH], g_last[N_CH];
    int vld_pct = 100;

    always #5 clk = ~clk;

    oht_multi #(
        .N_CH(N_CH), .CAL_W(CAL_W), .WIN(WIN), .RCT_CUT(RCT_CUT),
        .APT_LO(APT_LO), .APT_HI(APT_HI), .GOOD_REQ(GOOD_REQ)
    ) dut (
        .clk(clk), .rst(rst), .bit_in(bit_in), .bit_vld(bit_vld),
        .debug_mode(debug_mode), .dbg_sel(dbg_sel), .dbg_cal(dbg_cal),
        .cal_n(cal_n), .cal_p(cal_p), .valid(valid), .perm_fail(perm_fail),
        .any_valid(any_valid)
    );

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Negative result: p steps; positive: n steps; zero: window in range.
    function automatic int windowClass(input int ones);
        if (ones < WIN / 8)     return -3;
        if (ones < WIN / 4)     return -2;
        if (ones < APT_LO)      return -1;
        if (ones <= APT_HI)     return 0;
        if (ones < 3 * WIN / 4) return 1;
        if (ones < 7 * WIN / 8) return 2;
        return 3;
    endfunction

    task automatic modelReset();
        for (int c = 0; c < N_CH; c++) begin
            m_n[c] = 0; m_p[c] = 0; m_st[c] = ST_CAL; m_run[c] = 0; m_last[c] = 0;
            m_ones[c] = 0; m_samp[c] = 0; m_good[c] = 0;
        end
    endtask

    task automatic modelAdjust(input int c, input int step, input bit to_n);
        int tgt;
        int opp;
        tgt = to_n ? m_n[c] : m_p[c];
        opp = to_n ? m_p[c] : m_n[c];
        if (tgt < TMAX)   tgt = (tgt + step > TMAX) ? TMAX : tgt + step;
        else if (opp > 0) opp = (opp - step < 0) ? 0 : opp - step;
        else              m_st[c] = ST_FAIL;
        if (to_n) begin m_n[c] = tgt; m_p[c] = opp; end
        else      begin m_p[c] = tgt; m_n[c] = opp; end
    endtask

    task automatic modelStep(input logic [N_CH-1:0] b, input logic vld, input logic dm,
                             input int sel, input logic [2*CAL_W-1:0] dc);
        int cls;
        for (int c = 0; c < N_CH; c++) begin
            if (vld && m_st[c] != ST_FAIL) begin
                m_run[c]  = (m_run[c] > 0 && int'(b[c]) == m_last[c]) ? m_run[c] + 1 : 1;
                m_last[c] = int'(b[c]);
                if (m_run[c] >= RCT_CUT) begin
                    m_run[c] = 0; m_ones[c] = 0; m_samp[c] = 0; m_good[c] = 0;
                    m_st[c] = ST_CAL;
                    modelAdjust(c, 3, b[c]);
                end else begin
                    m_ones[c] += int'(b[c]);
                    m_samp[c] += 1;
                    if (m_samp[c] == WIN) begin
                        cls = windowClass(m_ones[c]);
                        m_ones[c] = 0; m_samp[c] = 0;
                        if (cls != 0) begin
                            m_good[c] = 0;
                            m_st[c] = ST_CAL;
                            modelAdjust(c, (cls < 0) ? -cls : cls, cls > 0);
                        end else if (m_st[c] == ST_CAL) begin
                            m_good[c] += 1;
                            if (m_good[c] >= GOOD_REQ) begin m_st[c] = ST_OK; m_good[c] = 0; end
                        end
                    end
                end
            end
            if (dm && sel == c) begin
                m_n[c] = int'(dc[2*CAL_W-1:CAL_W]);
                m_p[c] = int'(dc[CAL_W-1:0]);
            end
        end
    endtask

    task automatic compareAll();
        logic [N_CH*CAL_W-1:0] en, ep;
        logic [N_CH-1:0]       ev, ef;
        for (int c = 0; c < N_CH; c++) begin
            en[c*CAL_W +: CAL_W] = CAL_W'(m_n[c]);
            ep[c*CAL_W +: CAL_W] = CAL_W'(m_p[c]);
            ev[c] = (m_st[c] == ST_OK);
            ef[c] = (m_st[c] == ST_FAIL);
        end
        checkOutput("cal_n", 64'(cal_n), 64'(en));
        checkOutput("cal_p", 64'(cal_p), 64'(ep));
        checkOutput("valid", 64'(valid), 64'(ev));
        checkOutput("perm_fail", 64'(perm_fail), 64'(ef));
        checkOutput("any_valid", 64'(any_valid), 64'(|ev));
    endtask

    task automatic applyStimulus(input logic [N_CH-1:0] b, input logic vld, input logic r,
                                 input logic dm, input int sel, input logic [2*CAL_W-1:0] dc);
        @(negedge clk);
        bit_in = b; bit_vld = vld; rst = r; debug_mode = dm;
        dbg_sel = 2'(sel); dbg_cal = dc;
        @(posedge clk);
        if (r) modelReset();
        else   modelStep(b, vld, dm, sel, dc);
        #1;
        compareAll();
    endtask

    // Random bits at a chosen density, with runs broken at 7 unless a channel is held.
    task automatic makeBits(output logic [N_CH-1:0] b);
        logic v;
        for (int c = 0; c < N_CH; c++) begin
            if (g_hold[c] >= 0) begin
                v = (g_hold[c] != 0);
            end else begin
                v = ($urandom_range(0, 99) < g_pct[c]);
                if (g_run[c] >= 7 && int'(v) == g_last[c]) v = ~v;
            end
            g_run[c]  = (int'(v) == g_last[c]) ? g_run[c] + 1 : 1;
            g_last[c] = int'(v);
            b[c] = v;
        end
    endtask

    initial begin
        logic [N_CH-1:0]    b;
        logic [2*CAL_W-1:0] dc;
        int                 pcts[8] = '{5, 15, 30, 44, 56, 70, 85, 95};
        int                 r, sel;

        bit_in = '0; bit_vld = 1'b0; rst = 1'b1; debug_mode = 1'b0; dbg_sel = '0; dbg_cal = '0;
        modelReset();
        for (int c = 0; c < N_CH; c++) begin g_pct[c] = 50; g_hold[c] = -1; g_run[c] = 0; g_last[c] = 0; end

        repeat (3) applyStimulus('0, 1'b0, 1'b1, 1'b0, 0, '0);
        checkOutput("reset_cal_n", 64'(cal_n), 64'd0);
        checkOutput("reset_cal_p", 64'(cal_p), 64'd0);
        checkOutput("reset_flags", 64'({valid, perm_fail, any_valid}), 64'd0);

        // 0101... on every channel: two in-range windows of 512 ones each.
        for (int i = 0; i < 2048; i++) begin
            applyStimulus((i % 2 == 0) ? '1 : '0, 1'b1, 1'b0, 1'b0, 0, '0);
            if (i == 2046) checkOutput("valid_before_2048", 64'(valid), 64'd0);
        end
        checkOutput("valid_at_2048", 64'(valid), 64'hF);
        checkOutput("any_valid_at_2048", 64'(any_valid), 64'd1);
        checkOutput("trims_after_alt", 64'({cal_n, cal_p}), 64'd0);

        // Channel 0 held high for eight samples while the others keep alternating.
        for (int k = 0; k < 8; k++) begin
            b = ((2048 + k) % 2 == 0) ? '1 : '0;
            b[0] = 1'b1;
            applyStimulus(b, 1'b1, 1'b0, 1'b0, 0, '0);
            if (k == 6) checkOutput("rct_cal_n0_before", 64'(cal_n[5:0]), 64'd0);
        end
        checkOutput("rct_cal_n0", 64'(cal_n[5:0]), 64'd3);
        checkOutput("rct_valid", 64'(valid), 64'b1110);

        for (int ph = 0; ph < 12; ph++) begin
            if (ph % 4 == 3) applyStimulus('0, 1'b0, 1'b1, 1'b0, 0, '0);
            for (int c = 0; c < N_CH; c++) begin
                r = $urandom_range(0, 9);
                g_hold[c] = -1;
                if (r < 4)      g_pct[c] = 50;
                else if (r < 8) g_pct[c] = pcts[$urandom_range(0, 7)];
                else            g_hold[c] = $urandom_range(0, 1);
            end
            vld_pct = (ph % 3 == 0) ? 50 : 100;
            if ($urandom_range(0, 1) == 1) begin
                sel = $urandom_range(0, N_CH - 1);
                r = $urandom_range(0, 2);
                dc = (r == 0) ? {6'd0, 6'd63} : (r == 1) ? {6'd63, 6'd0} : 12'($urandom_range(0, 4095));
                repeat (3) begin
                    makeBits(b);
                    applyStimulus(b, ($urandom_range(0, 99) < vld_pct), 1'b0, 1'b1, sel, dc);
                end
            end
            for (int k = 0; k < 1100; k++) begin
                if (k == 40) for (int c = 0; c < N_CH; c++) g_hold[c] = -1;
                makeBits(b);
                applyStimulus(b, ($urandom_range(0, 99) < vld_pct), 1'b0, 1'b0, 0, '0);
            end
        end

        // Channel 2 forced to p=63/n=0, then a run of zeros makes its adjust impossible.
        applyStimulus('0, 1'b0, 1'b1, 1'b0, 0, '0);
        repeat (2) applyStimulus('0, 1'b0, 1'b0, 1'b1, 2, {6'd0, 6'd63});
        for (int k = 0; k < 12; k++) begin
            b = (k % 2 == 0) ? '1 : '0;
            b[2] = 1'b0;
            applyStimulus(b, 1'b1, 1'b0, 1'b0, 0, '0);
        end
        checkOutput("fail_perm_fail2", 64'(perm_fail[2]), 64'd1);
        checkOutput("fail_valid2", 64'(valid[2]), 64'd0);
        for (int c = 0; c < N_CH; c++) begin g_hold[c] = -1; g_pct[c] = 50; end
        for (int k = 0; k < 700; k++) begin
            makeBits(b);
            applyStimulus(b, 1'b1, 1'b0, 1'b0, 0, '0);
        end
        checkOutput("fail_sticky", 64'(perm_fail[2]), 64'd1);
        checkOutput("fail_trim_held", 64'(cal_p[17:12]), 64'd63);

        applyStimulus('1, 1'b1, 1'b1, 1'b0, 0, '0);
        checkOutput("midrst_trims", 64'({cal_n, cal_p}), 64'd0);
        checkOutput("midrst_flags", 64'({valid, perm_fail, any_valid}), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
